switch_input_ctrl: RTL and testbench

Input-side controller between the board slide switches and the single-cycle CPU input ports. Synchronizes the ten raw switches, debounces them as two 5-bit groups with one settle FSM per group, and commits each group to a stable, zero-extended 32-bit input-port register. A per-port change flag with an acknowledge handshake lets the CPU detect new operands without polling a moving value. Sits between the switch pins and the CPU's `in_port0`/`in_port1` inputs, replacing a direct combinational switch-to-port path.

---
 rtl/switch_input_ctrl_if.sv | 20 ++
 rtl/switch_input_ctrl.sv | 111 +++++++++++
 tb/tb_switch_input_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/switch_input_ctrl_if.sv
// rtl/switch_input_ctrl_if.sv - switch/CPU side signal bundle for switch_input_ctrl
interface switch_input_ctrl_if;
    logic [9:0]  sw;
    logic        ack0;
    logic        ack1;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic        chg0;
    logic        chg1;

    modport master (
        output sw, ack0, ack1,
        input  in_port0, in_port1, chg0, chg1
    );

    modport slave (
        input  sw, ack0, ack1,
        output in_port0, in_port1, chg0, chg1
    );
endinterface

// File: rtl/switch_input_ctrl.sv
// rtl/switch_input_ctrl.sv - synchronize, debounce and commit slide switches to CPU input ports
module switch_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    switch_input_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, SETTLE} state_t;

    // Last count value before a commit; cnt is compared here before incrementing so it never wraps.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]      s1;
    logic [9:0]      s2;
    logic [1:0]      ack;
    logic [1:0][4:0] committed_w;
    logic [1:0]      chg_w;

    assign ack = {bus.ack1, bus.ack0};

    // Two-flop synchronizer for the raw asynchronous switch levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.sw;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_grp
        state_t           state;
        state_t           state_n;
        logic [4:0]       cand;
        logic [4:0]       cand_n;
        logic [4:0]       committed;
        logic [4:0]       committed_n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic             chg;
        logic             chg_n;
        logic             commit;
        logic [4:0]       s2_g;

        assign s2_g = s2[g*5 +: 5];

        // Settle FSM next state: a candidate must hold for the full count, a return to the
        // committed value drops it, and any third value restarts the count on the new candidate.
        always_comb begin
            state_n     = state;
            cand_n      = cand;
            cnt_n       = cnt;
            committed_n = committed;
            commit      = 1'b0;
            case (state)
                IDLE: begin
                    if (s2_g != committed) begin
                        cand_n  = s2_g;
                        cnt_n   = '0;
                        state_n = SETTLE;
                    end
                end
                SETTLE: begin
                    if (s2_g == cand && cnt == LAST) begin
                        committed_n = cand;
                        commit      = 1'b1;
                        state_n     = IDLE;
                    end else if (s2_g == cand) begin
                        cnt_n = cnt + 1'b1;
                    end else if (s2_g == committed) begin
                        state_n = IDLE;
                    end else begin
                        cand_n = s2_g;
                        cnt_n  = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
            // A commit on the same edge as an ack keeps the flag so the new value is not missed.
            chg_n = commit ? 1'b1 : (ack[g] ? 1'b0 : chg);
        end

        // Group state, committed value and change flag registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= IDLE;
                cand      <= '0;
                cnt       <= '0;
                committed <= '0;
                chg       <= 1'b0;
            end else begin
                state     <= state_n;
                cand      <= cand_n;
                cnt       <= cnt_n;
                committed <= committed_n;
                chg       <= chg_n;
            end
        end

        assign committed_w[g] = committed;
        assign chg_w[g]       = chg;
    end

    assign bus.in_port0 = {27'b0, committed_w[0]};
    assign bus.in_port1 = {27'b0, committed_w[1]};
    assign bus.chg0     = chg_w[0];
    assign bus.chg1     = chg_w[1];
endmodule

// File: tb/tb_switch_input_ctrl.sv
// tb/tb_switch_input_ctrl.sv - self-checking bench for switch_input_ctrl
module tb_switch_input_ctrl;
    localparam int D = 4;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    logic model_on = 1'b0;

    switch_input_ctrl_if bus ();

    switch_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a group commits the value it has seen on D+1 consecutive
    // synchronized samples when that value differs from the one already committed.
    logic [9:0] p1 = '0;
    logic [9:0] p2 = '0;
    logic [4:0] m_com [2] = '{5'd0, 5'd0};
    logic [4:0] run_val [2] = '{5'd0, 5'd0};
    int         run_len [2] = '{0, 0};
    logic       m_chg [2] = '{1'b0, 1'b0};
    logic [4:0] mv;
    logic       mack;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1 = '0;
            p2 = '0;
            for (int g = 0; g < 2; g++) begin
                m_com[g]   = '0;
                run_val[g] = '0;
                run_len[g] = 0;
                m_chg[g]   = 1'b0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                mv   = p2[g*5 +: 5];
                mack = (g == 0) ? bus.ack0 : bus.ack1;
                if (mv == run_val[g]) begin
                    if (run_len[g] < 1000) run_len[g]++;
                end else begin
                    run_val[g] = mv;
                    run_len[g] = 1;
                end
                if (mv != m_com[g] && run_len[g] >= D + 1) begin
                    m_com[g] = mv;
                    m_chg[g] = 1'b1;
                end else if (mack) begin
                    m_chg[g] = 1'b0;
                end
            end
            p2 = p1;
            p1 = bus.sw;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_in_port0", bus.in_port0, {27'b0, m_com[0]});
            check("model_in_port1", bus.in_port1, {27'b0, m_com[1]});
            check("model_chg0", {31'b0, bus.chg0}, {31'b0, m_chg[0]});
            check("model_chg1", {31'b0, bus.chg1}, {31'b0, m_chg[1]});
        end
    end

    typedef struct {
        logic [9:0] sw;
        logic       a0;
        logic       a1;
        int         cyc;
        logic [4:0] e0;
        logic [4:0] e1;
        logic       c0;
        logic       c1;
    } vec_t;

    vec_t tbl [15];

    task automatic check_all(input string name, input logic [4:0] e0, input logic [4:0] e1,
                             input logic c0, input logic c1);
        check({name, "_p0"}, bus.in_port0, {27'b0, e0});
        check({name, "_p1"}, bus.in_port1, {27'b0, e1});
        check({name, "_c0"}, {31'b0, bus.chg0}, {31'b0, c0});
        check({name, "_c1"}, {31'b0, bus.chg1}, {31'b0, c1});
    endtask

    initial begin
        //          sw       a0    a1    cyc  e0     e1     c0    c1
        tbl[0]  = '{10'h015, 1'b0, 1'b0, 8, 5'h15, 5'h00, 1'b1, 1'b0};
        tbl[1]  = '{10'h015, 1'b1, 1'b0, 1, 5'h15, 5'h00, 1'b0, 1'b0};
        tbl[2]  = '{10'h016, 1'b0, 1'b0, 3, 5'h15, 5'h00, 1'b0, 1'b0};
        tbl[3]  = '{10'h015, 1'b0, 1'b0, 8, 5'h15, 5'h00, 1'b0, 1'b0};
        tbl[4]  = '{10'h0F5, 1'b0, 1'b0, 8, 5'h15, 5'h07, 1'b0, 1'b1};
        tbl[5]  = '{10'h3FF, 1'b0, 1'b0, 8, 5'h1F, 5'h1F, 1'b1, 1'b1};
        tbl[6]  = '{10'h3FF, 1'b1, 1'b1, 2, 5'h1F, 5'h1F, 1'b0, 1'b0};
        tbl[7]  = '{10'h000, 1'b0, 1'b0, 5, 5'h1F, 5'h1F, 1'b0, 1'b0};
        tbl[8]  = '{10'h000, 1'b0, 1'b0, 3, 5'h00, 5'h00, 1'b1, 1'b1};
        tbl[9]  = '{10'h000, 1'b1, 1'b1, 1, 5'h00, 5'h00, 1'b0, 1'b0};
        tbl[10] = '{10'h001, 1'b0, 1'b0, 3, 5'h00, 5'h00, 1'b0, 1'b0};
        tbl[11] = '{10'h000, 1'b0, 1'b0, 8, 5'h00, 5'h00, 1'b0, 1'b0};
        tbl[12] = '{10'h001, 1'b0, 1'b0, 5, 5'h00, 5'h00, 1'b0, 1'b0};
        tbl[13] = '{10'h000, 1'b0, 1'b0, 2, 5'h01, 5'h00, 1'b1, 1'b0};
        tbl[14] = '{10'h000, 1'b0, 1'b0, 8, 5'h00, 5'h00, 1'b1, 1'b0};

        // Reset held with all switches on: every output stays 0.
        reset    = 1'b0;
        bus.sw   = 10'h3FF;
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        check_all("reset_held", 5'h00, 5'h00, 1'b0, 1'b0);

        // Release: R is the first edge after release, commit lands on R+6.
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_all("reset_r5", 5'h00, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_all("reset_r6", 5'h1F, 5'h1F, 1'b1, 1'b1);

        // Return to all-zero and acknowledge, giving a clean start for the table.
        bus.sw = 10'h000;
        repeat (8) @(negedge clk);
        bus.ack0 = 1'b1;
        bus.ack1 = 1'b1;
        @(negedge clk);
        check_all("start_state", 5'h00, 5'h00, 1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            bus.sw   = tbl[i].sw;
            bus.ack0 = tbl[i].a0;
            bus.ack1 = tbl[i].a1;
            repeat (tbl[i].cyc) @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].c0, tbl[i].c1);
        end

        // Re-candidate: group 1 shows 3 briefly, then 7 held; one commit at R+6 of the 7.
        bus.ack0 = 1'b1;
        @(negedge clk);
        bus.ack0 = 1'b0;
        bus.sw   = 10'h060;
        repeat (2) @(negedge clk);
        bus.sw = 10'h0E0;
        repeat (6) @(negedge clk);
        check_all("recand_r5", 5'h00, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_all("recand_r6", 5'h00, 5'h07, 1'b0, 1'b1);

        // Handshake: ack clears the flag on the next cycle.
        bus.sw = 10'h0EA;
        repeat (8) @(negedge clk);
        check_all("hs_commit", 5'h0A, 5'h07, 1'b1, 1'b1);
        bus.ack0 = 1'b1;
        @(negedge clk);
        bus.ack0 = 1'b0;
        check("hs_ack_clears", {31'b0, bus.chg0}, 32'd0);

        // Commit and ack on the same edge: the flag stays set.
        bus.sw = 10'h0EB;
        repeat (6) @(negedge clk);
        check("hs_pre_commit_p0", bus.in_port0, 32'h0A);
        bus.ack0 = 1'b1;
        @(negedge clk);
        bus.ack0 = 1'b0;
        check_all("hs_same_edge", 5'h0B, 5'h07, 1'b1, 1'b1);
        @(negedge clk);
        check("hs_flag_kept", {31'b0, bus.chg0}, 32'd1);

        // Reset two cycles into SETTLE on group 1.
        bus.sw = 10'h12B;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all("midsettle_async", 5'h00, 5'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_all("midsettle_r5", 5'h00, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        check_all("midsettle_r6", 5'h0B, 5'h09, 1'b1, 1'b1);

        // Randomized bouncing switches and acks against the reference model.
        for (int n = 0; n < 250; n++) begin
            int          pick;
            logic [9:0]  prev;
            prev = bus.sw;
            pick = int'($urandom_range(0, 9));
            if (pick < 4)      bus.sw = 10'($urandom);
            else if (pick < 7) bus.sw = prev ^ (10'd1 << $urandom_range(0, 9));
            bus.ack0 = ($urandom_range(0, 3) == 0);
            bus.ack1 = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
